// File: rtl/csr_irq_timer.sv
// csr_irq_timer: exception/interrupt CSR unit (CRMD, PRMD, ECFG, ESTAT, ERA,
// EENTRY, SAVEn, TID, TCFG, TVAL, TICLR) with a one-shot/periodic countdown timer.
// Define CSR_STABLE_CNT_EN to add the 64-bit stable counter and its cnt_* ports.
module csr_irq_timer #(
   parameter int NUM_HWI  = 8,
   parameter int TIMER_W  = 32,
   parameter int NUM_SAVE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [13:0]        csr_addr,
   input  logic               csr_we,
   input  logic [31:0]        csr_wmask,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   input  logic [NUM_HWI-1:0] hw_int_in,
   input  logic               ipi_in,
   input  logic               wb_exception,
   input  logic [5:0]         wb_ecode,
   input  logic [8:0]         wb_esubcode,
   input  logic [31:0]        wb_pc,
   input  logic               ertn_flush,
   output logic [31:0]        exception_entry,
   output logic [31:0]        ertn_entry,
`ifdef CSR_STABLE_CNT_EN
   output logic [31:0]        cnt_lo,
   output logic [31:0]        cnt_hi,
   output logic [31:0]        cnt_id,
`endif
   output logic               int_pending
);

   localparam logic [13:0] ADDR_CRMD   = 14'h000;
   localparam logic [13:0] ADDR_PRMD   = 14'h001;
   localparam logic [13:0] ADDR_ECFG   = 14'h004;
   localparam logic [13:0] ADDR_ESTAT  = 14'h005;
   localparam logic [13:0] ADDR_ERA    = 14'h006;
   localparam logic [13:0] ADDR_EENTRY = 14'h00C;
   localparam logic [13:0] ADDR_SAVE0  = 14'h030;
   localparam logic [13:0] ADDR_TID    = 14'h040;
   localparam logic [13:0] ADDR_TCFG   = 14'h041;
   localparam logic [13:0] ADDR_TVAL   = 14'h042;
   localparam logic [13:0] ADDR_TICLR  = 14'h044;
   localparam logic [13:0] SAVE_END    = 14'(ADDR_SAVE0 + NUM_SAVE);

   // Software-writable bits of each register; everything else is RO or reserved.
   localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
   localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
   localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
   localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
   localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
   localparam logic [31:0] TCFG_WMASK   = 32'((33'd1 << TIMER_W) - 33'd1);

   localparam logic [0:0] TIMER_IDLE = 1'b0;
   localparam logic [0:0] TIMER_RUN  = 1'b1;

   function automatic logic [31:0] wr_merge(input logic [31:0] old_v, input logic [31:0] wmask,
                                            input logic [31:0] wdata, input logic [31:0] rw_mask);
      logic [31:0] m;
      m = wmask & rw_mask;
      return (old_v & ~m) | (wdata & m);
   endfunction

   logic [31:0]        crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, era_q, era_d;
   logic [31:0]        eentry_q, eentry_d, tid_q, tid_d, tcfg_q, tcfg_d, tcfg_new;
   logic [12:0]        is_q, is_d;
   logic [5:0]         ecode_q, ecode_d;
   logic [8:0]         esubcode_q, esubcode_d;
   logic [1:0]         is_sw_d;
   logic [7:0]         hw_ext;
   logic [31:0]        estat_rd, estat_wr;
   logic [TIMER_W-1:0] tval_q, tval_d;
   logic [0:0]         timer_state_q, timer_state_d;
   logic               tcfg_wr, ticlr_clr, expire, save_hit;
   logic [3:0]         save_idx;
   logic [31:0]        save_q [NUM_SAVE];

   assign estat_rd  = {1'b0, esubcode_q, ecode_q, 3'b000, is_q};
   assign tcfg_wr   = csr_we && (csr_addr == ADDR_TCFG);
   assign tcfg_new  = wr_merge(tcfg_q, csr_wmask, csr_wdata, TCFG_WMASK);
   assign ticlr_clr = csr_we && (csr_addr == ADDR_TICLR) && csr_wdata[0] && csr_wmask[0];
   assign save_hit  = (csr_addr >= ADDR_SAVE0) && (csr_addr < SAVE_END);
   assign save_idx  = csr_addr[3:0];

   assign exception_entry = {eentry_q[31:6], 6'b0};
   assign ertn_entry      = era_q;
   assign int_pending     = (|(is_q & ecfg_q[12:0])) & crmd_q[2];

   // Next state of the control/status registers: exception > ERTN > CSR write.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      crmd_d     = crmd_q;
      prmd_d     = prmd_q;
      era_d      = era_q;
      ecode_d    = ecode_q;
      esubcode_d = esubcode_q;
      is_sw_d    = is_q[1:0];
      estat_wr   = wr_merge(estat_rd, csr_wmask, csr_wdata, ESTAT_WMASK);
      ecfg_d     = ecfg_q;
      eentry_d   = eentry_q;
      tid_d      = tid_q;
      tcfg_d     = tcfg_wr ? tcfg_new : tcfg_q;
      hw_ext     = '0;
      hw_ext[NUM_HWI-1:0] = hw_int_in;
      if (wb_exception) begin
         prmd_d[2:0] = crmd_q[2:0];
         crmd_d[2:0] = 3'b000;
         era_d       = wb_pc;
         ecode_d     = wb_ecode;
         esubcode_d  = wb_esubcode;
      end else if (ertn_flush) begin
         crmd_d[2:0] = prmd_q[2:0];
      end else if (csr_we) begin
         case (csr_addr)
            ADDR_CRMD:  crmd_d  = wr_merge(crmd_q, csr_wmask, csr_wdata, CRMD_WMASK);
            ADDR_PRMD:  prmd_d  = wr_merge(prmd_q, csr_wmask, csr_wdata, PRMD_WMASK);
            ADDR_ESTAT: is_sw_d = estat_wr[1:0];
            ADDR_ERA:   era_d   = csr_wdata & csr_wmask | era_q & ~csr_wmask;
            default: ;
         endcase
      end
      if (csr_we) begin
         case (csr_addr)
            ADDR_ECFG:   ecfg_d   = wr_merge(ecfg_q, csr_wmask, csr_wdata, ECFG_WMASK);
            ADDR_EENTRY: eentry_d = wr_merge(eentry_q, csr_wmask, csr_wdata, EENTRY_WMASK);
            ADDR_TID:    tid_d    = wr_merge(tid_q, csr_wmask, csr_wdata, 32'hFFFF_FFFF);
            default: ;
         endcase
      end
      // IS[12:2] follow the hardware sources only; a TICLR in the expiry cycle loses.
      is_d = {ipi_in, expire | (is_q[11] & ~ticlr_clr), 1'b0, hw_ext, is_sw_d};
   end

   // Timer FSM: a TCFG write (re)starts or stops it, otherwise count down and expire.
   always_comb begin
      timer_state_d = timer_state_q;
      tval_d        = tval_q;
      expire        = 1'b0;
      if (tcfg_wr) begin
         if (tcfg_new[0]) begin
            tval_d        = {tcfg_new[TIMER_W-1:2], 2'b00};
            timer_state_d = TIMER_RUN;
         end else begin
            timer_state_d = TIMER_IDLE;
         end
      end else if (timer_state_q == TIMER_RUN) begin
         if (tval_q != '0) begin
            tval_d = tval_q - TIMER_W'(1);
         end else begin
            expire = 1'b1;
            if (tcfg_q[1]) begin
               tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
            end else begin
               tval_d        = '1;
               timer_state_d = TIMER_IDLE;
            end
         end
      end
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         crmd_q        <= 32'h0000_0008;
         prmd_q        <= '0;
         ecfg_q        <= '0;
         era_q         <= '0;
         eentry_q      <= '0;
         tid_q         <= '0;
         tcfg_q        <= '0;
         is_q          <= '0;
         ecode_q       <= '0;
         esubcode_q    <= '0;
         tval_q        <= '0;
         timer_state_q <= TIMER_IDLE;
      end else begin
         crmd_q        <= crmd_d;
         prmd_q        <= prmd_d;
         ecfg_q        <= ecfg_d;
         era_q         <= era_d;
         eentry_q      <= eentry_d;
         tid_q         <= tid_d;
         tcfg_q        <= tcfg_d;
         is_q          <= is_d;
         ecode_q       <= ecode_d;
         esubcode_q    <= esubcode_d;
         tval_q        <= tval_d;
         timer_state_q <= timer_state_d;
      end
   end

   // SAVE scratch registers.
   always_ff @(posedge clk) begin
      // NOTE: this small array is architecturally reset to zero, so it is a flop bank, not a RAM.
      for (int i = 0; i < NUM_SAVE; i++) begin
         if (rst) begin
            save_q[i] <= '0;
         end else if (csr_we && save_hit && (save_idx == 4'(i))) begin
            save_q[i] <= wr_merge(save_q[i], csr_wmask, csr_wdata, 32'hFFFF_FFFF);
         end
      end
   end

   // Combinational CSR read of the pre-write register values.
   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         ADDR_CRMD:   csr_rdata = crmd_q;
         ADDR_PRMD:   csr_rdata = prmd_q;
         ADDR_ECFG:   csr_rdata = ecfg_q;
         ADDR_ESTAT:  csr_rdata = estat_rd;
         ADDR_ERA:    csr_rdata = era_q;
         ADDR_EENTRY: csr_rdata = eentry_q;
         ADDR_TID:    csr_rdata = tid_q;
         ADDR_TCFG:   csr_rdata = tcfg_q;
         ADDR_TVAL:   csr_rdata = 32'(tval_q);
         default: ;
      endcase
      for (int i = 0; i < NUM_SAVE; i++) begin
         if (save_hit && (save_idx == 4'(i))) csr_rdata = save_q[i];
      end
   end

`ifdef CSR_STABLE_CNT_EN
   logic [63:0] cnt_q;

   // Free-running stable counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_q + 64'd1;
   end

   assign cnt_lo = cnt_q[31:0];
   assign cnt_hi = cnt_q[63:32];
   assign cnt_id = tid_q;
`endif

endmodule

// File: tb/tb_csr_irq_timer.sv
// tb_csr_irq_timer: directed bench for csr_irq_timer with a scoreboard of expected values.
// A second, small instance (NUM_HWI=2, TIMER_W=16, NUM_SAVE=1) shares the CSR bus.
module tb_csr_irq_timer;

   localparam logic [13:0] A_CRMD   = 14'h000;
   localparam logic [13:0] A_PRMD   = 14'h001;
   localparam logic [13:0] A_ECFG   = 14'h004;
   localparam logic [13:0] A_ESTAT  = 14'h005;
   localparam logic [13:0] A_ERA    = 14'h006;
   localparam logic [13:0] A_EENTRY = 14'h00C;
   localparam logic [13:0] A_SAVE0  = 14'h030;
   localparam logic [13:0] A_SAVE1  = 14'h031;
   localparam logic [13:0] A_SAVE3  = 14'h033;
   localparam logic [13:0] A_TID    = 14'h040;
   localparam logic [13:0] A_TCFG   = 14'h041;
   localparam logic [13:0] A_TVAL   = 14'h042;
   localparam logic [13:0] A_TICLR  = 14'h044;

   logic        clk, rst, csr_we, ipi_in, wb_exception, ertn_flush;
   logic [13:0] csr_addr;
   logic [31:0] csr_wmask, csr_wdata, wb_pc;
   logic [7:0]  hw_int_in;
   logic [1:0]  s_hw;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] csr_rdata, exception_entry, ertn_entry;
   logic [31:0] s_rdata, s_exc_entry, s_ertn_entry;
   logic        int_pending, s_int_pending;
`ifdef CSR_STABLE_CNT_EN
   logic [31:0] cnt_lo, cnt_hi, cnt_id, s_cnt_lo, s_cnt_hi, s_cnt_id;
`endif

   csr_irq_timer u_dut (
      .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wmask(csr_wmask),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .hw_int_in(hw_int_in), .ipi_in(ipi_in),
      .wb_exception(wb_exception), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .ertn_flush(ertn_flush), .exception_entry(exception_entry), .ertn_entry(ertn_entry),
`ifdef CSR_STABLE_CNT_EN
      .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .cnt_id(cnt_id),
`endif
      .int_pending(int_pending)
   );

   csr_irq_timer #(.NUM_HWI(2), .TIMER_W(16), .NUM_SAVE(1)) u_small (
      .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wmask(csr_wmask),
      .csr_wdata(csr_wdata), .csr_rdata(s_rdata), .hw_int_in(s_hw), .ipi_in(ipi_in),
      .wb_exception(wb_exception), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .ertn_flush(ertn_flush), .exception_entry(s_exc_entry), .ertn_entry(s_ertn_entry),
`ifdef CSR_STABLE_CNT_EN
      .cnt_lo(s_cnt_lo), .cnt_hi(s_cnt_hi), .cnt_id(s_cnt_id),
`endif
      .int_pending(s_int_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Queue the expected value at the point the stimulus defines it.
   task automatic push(input string tag, input logic [31:0] exp);
      sb_q.push_back('{tag, exp});
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %h with no expectation queued", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
      csr_addr  = a;
      csr_wdata = d;
      csr_wmask = m;
      csr_we    = 1'b1;
      tick();
      csr_we    = 1'b0;
      csr_wmask = '0;
   endtask

   task automatic rd_chk(input logic [13:0] a, input logic [31:0] exp, input string tag);
      push(tag, exp);
      csr_addr = a;
      #1;
      check(csr_rdata);
   endtask

   task automatic rd_chk_s(input logic [13:0] a, input logic [31:0] exp, input string tag);
      push(tag, exp);
      csr_addr = a;
      #1;
      check(s_rdata);
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b1; csr_we = 1'b0; csr_addr = '0; csr_wmask = '0; csr_wdata = '0;
      hw_int_in = '0; s_hw = '0; ipi_in = 1'b0; wb_exception = 1'b0; wb_ecode = '0;
      wb_esubcode = '0; wb_pc = '0; ertn_flush = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      rd_chk(A_CRMD, 32'h0000_0008, "rst_crmd");
      rd_chk(A_PRMD, 32'h0, "rst_prmd");
      rd_chk(A_ESTAT, 32'h0, "rst_estat");
      rd_chk(A_TVAL, 32'h0, "rst_tval");
      push("rst_int_pending", 32'h0);  check({31'b0, int_pending});
      push("rst_exc_entry", 32'h0);    check(exception_entry);
      push("rst_ertn_entry", 32'h0);   check(ertn_entry);

      // Unimplemented address, TICLR read, SAVE registers
      csr_write(14'h007, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_chk(14'h007, 32'h0, "unimpl_rd");
      rd_chk(A_TICLR, 32'h0, "ticlr_rd");
      csr_write(A_SAVE0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      csr_write(A_SAVE3, 32'h1234_5678, 32'hFFFF_FFFF);
      csr_write(14'h034, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_chk(A_SAVE0, 32'hDEAD_BEEF, "save0");
      rd_chk(A_SAVE3, 32'h1234_5678, "save3");
      rd_chk(14'h034, 32'h0, "save_oob");
      csr_write(A_SAVE0, 32'h1111_2222, 32'h0000_FFFF);
      rd_chk(A_SAVE0, 32'hDEAD_2222, "save0_wmask");
      csr_addr = A_SAVE1; csr_wdata = 32'h0000_0055; csr_wmask = '1; csr_we = 1'b1;
      #1;
      push("rd_during_wr_old", 32'h0); check(csr_rdata);
      tick();
      csr_we = 1'b0;
      rd_chk(A_SAVE1, 32'h0000_0055, "rd_after_wr_new");

      // Exception entry and ERTN
      csr_write(A_EENTRY, 32'h1C00_0047, 32'hFFFF_FFFF);
      rd_chk(A_EENTRY, 32'h1C00_0040, "eentry");
      csr_write(A_CRMD, 32'h4, 32'h4);
      rd_chk(A_CRMD, 32'h0000_000C, "crmd_ie");
      wb_exception = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
      #1;
      push("exc_entry", 32'h1C00_0040); check(exception_entry);
      tick();
      wb_exception = 1'b0;
      rd_chk(A_CRMD, 32'h0000_0008, "exc_crmd");
      rd_chk(A_PRMD, 32'h0000_0004, "exc_prmd");
      rd_chk(A_ERA, 32'h1C00_0100, "exc_era");
      rd_chk(A_ESTAT, 32'h000B_0000, "exc_estat");
      push("exc_ertn_entry", 32'h1C00_0100); check(ertn_entry);
      ertn_flush = 1'b1;
      tick();
      ertn_flush = 1'b0;
      rd_chk(A_CRMD, 32'h0000_000C, "ertn_crmd");

      // Exception beats ERTN and a same-cycle CSR write
      csr_write(A_CRMD, 32'h3, 32'h3);
      rd_chk(A_CRMD, 32'h0000_000F, "crmd_plv3");
      wb_exception = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h3F; wb_esubcode = 9'h1FF;
      wb_pc = 32'h2000_0000; csr_addr = A_ERA; csr_wdata = 32'hAAAA_0000; csr_wmask = '1; csr_we = 1'b1;
      tick();
      wb_exception = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
      rd_chk(A_CRMD, 32'h0000_0008, "prio_crmd");
      rd_chk(A_PRMD, 32'h0000_0007, "prio_prmd");
      rd_chk(A_ERA, 32'h2000_0000, "prio_era");
      rd_chk(A_ESTAT, 32'h7FFF_0000, "prio_estat");
      ertn_flush = 1'b1; csr_addr = A_CRMD; csr_wdata = 32'h0; csr_wmask = '1; csr_we = 1'b1;
      tick();
      ertn_flush = 1'b0; csr_we = 1'b0;
      rd_chk(A_CRMD, 32'h0000_000F, "ertn_beats_we");
      csr_write(A_CRMD, 32'h0, 32'h3);
      rd_chk(A_CRMD, 32'h0000_000C, "crmd_plv0");

      // Interrupt sources and pending
      csr_write(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_chk(A_ECFG, 32'h0000_1BFF, "ecfg_mask");
      csr_write(A_ECFG, 32'h4, 32'hFFFF_FFFF);
      hw_int_in = 8'h01;
      #1;
      push("hwi_latency", 32'h0); check({31'b0, int_pending});
      tick();
      rd_chk(A_ESTAT, 32'h7FFF_0004, "hwi_is2");
      push("hwi_pending", 32'h1); check({31'b0, int_pending});
      csr_write(A_ESTAT, 32'h0, 32'hFFFF_FFFF);
      rd_chk(A_ESTAT, 32'h7FFF_0004, "estat_ro");
      csr_write(A_ESTAT, 32'h3, 32'h3);
      rd_chk(A_ESTAT, 32'h7FFF_0007, "estat_sw");
      ipi_in = 1'b1; hw_int_in = 8'hFF;
      tick();
      rd_chk(A_ESTAT, 32'h7FFF_13FF, "ipi_hw_all");
      ipi_in = 1'b0; hw_int_in = 8'h00;
      tick();
      csr_write(A_ESTAT, 32'h0, 32'h3);
      rd_chk(A_ESTAT, 32'h7FFF_0000, "is_clear");
      push("is_clear_pending", 32'h0); check({31'b0, int_pending});
      csr_write(A_ECFG, 32'h800, 32'hFFFF_FFFF);

      // One-shot timer
      csr_write(A_TCFG, 32'h0000_0011, 32'hFFFF_FFFF);
      rd_chk(A_TVAL, 32'h0000_0010, "os_load");
      rd_chk(A_TCFG, 32'h0000_0011, "os_tcfg");
      repeat (16) tick();
      rd_chk(A_TVAL, 32'h0, "os_zero");
      rd_chk(A_ESTAT, 32'h7FFF_0000, "os_not_yet");
      tick();
      rd_chk(A_ESTAT, 32'h7FFF_0800, "os_expire");
      rd_chk(A_TVAL, 32'hFFFF_FFFF, "os_tval_ones");
      push("os_pending", 32'h1); check({31'b0, int_pending});
      repeat (3) tick();
      rd_chk(A_TVAL, 32'hFFFF_FFFF, "os_idle");
      csr_write(A_TVAL, 32'h0, 32'hFFFF_FFFF);
      rd_chk(A_TVAL, 32'hFFFF_FFFF, "tval_ro");
      csr_write(A_TICLR, 32'h1, 32'h1);
      rd_chk(A_ESTAT, 32'h7FFF_0000, "ticlr");
      push("ticlr_pending", 32'h0); check({31'b0, int_pending});

      // Periodic timer and TICLR racing an expiry
      csr_write(A_TCFG, 32'h0000_0007, 32'hFFFF_FFFF);
      rd_chk(A_TVAL, 32'h4, "per_load");
      repeat (4) tick();
      rd_chk(A_TVAL, 32'h0, "per_zero");
      rd_chk(A_ESTAT, 32'h7FFF_0000, "per_not_yet");
      tick();
      rd_chk(A_TVAL, 32'h4, "per_reload");
      rd_chk(A_ESTAT, 32'h7FFF_0800, "per_expire");
      csr_write(A_TICLR, 32'h1, 32'h1);
      rd_chk(A_ESTAT, 32'h7FFF_0000, "per_ticlr");
      rd_chk(A_TVAL, 32'h3, "per_count");
      repeat (3) tick();
      rd_chk(A_TVAL, 32'h0, "per_zero2");
      csr_write(A_TICLR, 32'h1, 32'h1);
      rd_chk(A_ESTAT, 32'h7FFF_0800, "ticlr_vs_expire");
      rd_chk(A_TVAL, 32'h4, "per_reload2");
      csr_write(A_TCFG, 32'h0000_0006, 32'hFFFF_FFFF);
      repeat (3) tick();
      rd_chk(A_TVAL, 32'h4, "stop_frozen");
      csr_write(A_TICLR, 32'h1, 32'h1);

      // InitVal=0 periodic fires every cycle
      csr_write(A_TCFG, 32'h0000_0003, 32'hFFFF_FFFF);
      tick();
      rd_chk(A_ESTAT, 32'h7FFF_0800, "iv0_expire");
      csr_write(A_TICLR, 32'h1, 32'h1);
      rd_chk(A_ESTAT, 32'h7FFF_0800, "iv0_ticlr_lost");
      csr_write(A_TCFG, 32'h0, 32'hFFFF_FFFF);
      csr_write(A_TICLR, 32'h1, 32'h1);
      rd_chk(A_ESTAT, 32'h7FFF_0000, "iv0_stopped");

      // Reset mid-count
      csr_write(A_TCFG, 32'h0000_0011, 32'hFFFF_FFFF);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_chk(A_TVAL, 32'h0, "rst2_tval");
      rd_chk(A_ESTAT, 32'h0, "rst2_estat");
      rd_chk(A_CRMD, 32'h8, "rst2_crmd");
      rd_chk(A_TCFG, 32'h0, "rst2_tcfg");
      rd_chk(A_SAVE0, 32'h0, "rst2_save0");
      repeat (20) tick();
      rd_chk(A_ESTAT, 32'h0, "rst2_no_expiry");
      rd_chk(A_TVAL, 32'h0, "rst2_tval_idle");

      // Small configuration
      s_hw = 2'b11;
      tick();
      rd_chk_s(A_ESTAT, 32'h0000_000C, "s_hw_is");
      rd_chk(A_ESTAT, 32'h0, "main_hw_quiet");
      csr_write(A_TCFG, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      rd_chk_s(A_TCFG, 32'h0000_FFFD, "s_tcfg");
      rd_chk_s(A_TVAL, 32'h0000_FFFC, "s_tval_load");
      rd_chk(A_TVAL, 32'hFFFF_FFFC, "main_tval_load");
      tick();
      rd_chk_s(A_TVAL, 32'h0000_FFFB, "s_tval_dec");
      rd_chk_s(A_SAVE1, 32'h0, "s_save_oob");

`ifdef CSR_STABLE_CNT_EN
      // Stable counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("cnt_rst_lo", 32'h0); check(cnt_lo);
      push("cnt_rst_hi", 32'h0); check(cnt_hi);
      repeat (7) tick();
      push("cnt_seven", 32'h7); check(cnt_lo);
      csr_write(A_TID, 32'hCAFE_0001, 32'hFFFF_FFFF);
      push("cnt_eight", 32'h8); check(cnt_lo);
      push("cnt_id", 32'hCAFE_0001); check(cnt_id);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
